// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MDU_FAST_SPECIAL_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in 2 cycles.
module mdu #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         w_arith,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_N   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MIN_W32 = {{(N-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_reg, state_next;

  logic [2:0]     op_reg;
  logic           w_reg, neg_reg, special_reg;
  logic [N-1:0]   ma_reg, mb_reg, special_val_reg;
  logic [2*N-1:0] acc_reg;
  logic [CW-1:0]  cnt_reg;

  // Operand preparation on the incoming request
  logic         sa_en, sb_en, is_div, a_neg, b_neg, neg_next;
  logic         div0, ovf, mul_zero, special, fast_path, accept;
  logic [N-1:0] a_sext, b_sext, a_ext, b_ext, a_mag, b_mag, special_val;

  always_comb begin
    sa_en = 1'b1;
    sb_en = 1'b1;
    if (op[2]) begin
      sa_en = ~op[0];
      sb_en = ~op[0];
    end else if (!w_arith) begin
      case (op[1:0])
        2'd2:    sb_en = 1'b0;
        2'd3:    begin sa_en = 1'b0; sb_en = 1'b0; end
        default: ;
      endcase
    end
  end

  assign is_div   = op[2];
  assign a_sext   = w_arith ? {{(N-32){a[31]}}, a[31:0]} : a;
  assign b_sext   = w_arith ? {{(N-32){b[31]}}, b[31:0]} : b;
  assign a_ext    = (w_arith && !sa_en) ? {{(N-32){1'b0}}, a[31:0]} : a_sext;
  assign b_ext    = (w_arith && !sb_en) ? {{(N-32){1'b0}}, b[31:0]} : b_sext;
  assign a_neg    = sa_en & a_ext[N-1];
  assign b_neg    = sb_en & b_ext[N-1];
  assign a_mag    = a_neg ? -a_ext : a_ext;
  assign b_mag    = b_neg ? -b_ext : b_ext;
  assign neg_next = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);

  assign div0     = is_div & (b_ext == '0);
  assign ovf      = is_div & sa_en & (a_ext == (w_arith ? MIN_W32 : MIN_N)) & (b_ext == '1);
  assign mul_zero = ~is_div & ((a_ext == '0) | (b_ext == '0));
  assign special  = div0 | ovf | mul_zero;

  always_comb begin
    special_val = '0;
    if (div0)
      special_val = op[1] ? a_sext : '1;
    else if (ovf && !op[1])
      special_val = a_sext;
  end

`ifdef MDU_FAST_SPECIAL_EN
  assign fast_path = special;
`else
  assign fast_path = 1'b0;
`endif

  assign accept = start && (state_reg == IDLE || state_reg == DONE);
  assign busy   = (state_reg == CALC) || (state_reg == FIX);
  assign done   = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Fast-path requests reuse FIX as their single write cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = accept ? (fast_path ? FIX : CALC) : IDLE;
      CALC:       state_next = (cnt_reg == '0) ? FIX : CALC;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // One iteration: multiply consumes multiplier bits MSB first; divide shifts in dividend bits
  logic [N:0]     trial;
  logic           ge;
  logic [N-1:0]   diff, new_rem;
  logic [2*N-1:0] mul_step, step_val;

  assign trial    = {acc_reg[2*N-1:N], ma_reg[cnt_reg]};
  assign ge       = trial >= {1'b0, mb_reg};
  assign diff     = trial[N-1:0] - mb_reg;
  assign new_rem  = ge ? diff : trial[N-1:0];
  assign mul_step = {acc_reg[2*N-2:0], 1'b0} + {{N{1'b0}}, (mb_reg[cnt_reg] ? ma_reg : {N{1'b0}})};
  assign step_val = op_reg[2] ? {new_rem, acc_reg[N-2:0], ge} : mul_step;

  logic [2*N-1:0] prod_s;
  logic [N-1:0]   div_sel, div_s, raw_val, fix_val;

  assign prod_s  = neg_reg ? -acc_reg : acc_reg;
  assign div_sel = op_reg[1] ? acc_reg[2*N-1:N] : acc_reg[N-1:0];
  assign div_s   = neg_reg ? -div_sel : div_sel;
  assign raw_val = op_reg[2] ? div_s
                 : ((op_reg[1:0] == 2'd0 || w_reg) ? prod_s[N-1:0] : prod_s[2*N-1:N]);
  assign fix_val = special_reg ? special_val_reg
                 : (w_reg ? {{(N-32){raw_val[31]}}, raw_val[31:0]} : raw_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg          <= '0;
      w_reg           <= 1'b0;
      neg_reg         <= 1'b0;
      special_reg     <= 1'b0;
      ma_reg          <= '0;
      mb_reg          <= '0;
      special_val_reg <= '0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      result          <= '0;
    end else if (accept) begin
      op_reg          <= op;
      w_reg           <= w_arith;
      neg_reg         <= neg_next;
      special_reg     <= special;
      ma_reg          <= a_mag;
      mb_reg          <= b_mag;
      special_val_reg <= special_val;
      acc_reg         <= '0;
      cnt_reg         <= w_arith ? CW'(31) : CW'(N-1);
    end else if (state_reg == CALC) begin
      acc_reg <= step_val;
      if (cnt_reg != '0)
        cnt_reg <= cnt_reg - 1'b1;
    end else if (state_reg == FIX) begin
      result <= fix_val;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table through a result scoreboard plus handshake corner sequences.
module tb_mdu;
  localparam int N = 64;
`ifdef MDU_FAST_SPECIAL_EN
  localparam int SP  = 2;
  localparam int SPW = 2;
`else
  localparam int SP  = 66;
  localparam int SPW = 34;
`endif

  logic         clk = 1'b0;
  logic         reset, start, w_arith, busy, done;
  logic [2:0]   op;
  logic [N-1:0] a, b, result;

  always #5 clk = ~clk;

  mdu #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .w_arith(w_arith),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic         w;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
    int           lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input string name, input logic [2:0] o, input logic w,
                     input logic [N-1:0] aa, input logic [N-1:0] bb,
                     input logic [N-1:0] ex, input int lat);
    vec_t v;
    v.name = name; v.op = o; v.w = w; v.a = aa; v.b = bb; v.exp = ex; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive a request at the current (negedge) time and record its expected result
  task automatic issue(input logic [2:0] o, input logic w, input logic [N-1:0] aa,
                       input logic [N-1:0] bb, input logic [N-1:0] ex);
    op = o; w_arith = w; a = aa; b = bb; start = 1'b1;
    exp_q.push_back(ex);
  endtask

  // Returns at the negedge of the done cycle; glitch>0 pulses a bogus start after that many edges
  task automatic wait_done(input string name, input int lat, input int glitch);
    int cyc = 0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    logic [N-1:0] req;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (cyc == glitch) begin
        start = 1'b1; op = 3'd5; a = 64'd1; b = 64'd1;
      end
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s.timeout: no done within %0d cycles, required %0d", name, cyc, lat);
      exp_q.delete();
    end else begin
      check({name, ".latency"}, 64'(cyc), 64'(lat));
      check({name, ".busy_during"}, 64'(busy_ok), 64'd1);
      check({name, ".busy_at_done"}, 64'(busy), 64'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s.scoreboard: done with no pending result, got %h", name, result);
      end else begin
        req = exp_q.pop_front();
        check({name, ".result"}, result, req);
      end
      $display("%s: result=%h cycles=%0d", name, result, cyc);
    end
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; start = 1'b0; op = 3'd0; w_arith = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.result", result, 64'd0);
    reset = 1'b0;

    add("mul_neg",     3'd0, 1'b0, -64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    add("mulhu_max",   3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    add("mulhsu",      3'd2, 1'b0, -64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    add("mulh_pos",    3'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
        64'h3FFF_FFFF_FFFF_FFFF, 66);
    add("div_neg",     3'd4, 1'b0, -64'd7, 64'd2, -64'd3, 66);
    add("rem_neg",     3'd6, 1'b0, -64'd7, 64'd2, -64'd1, 66);
    add("div_negb",    3'd4, 1'b0, 64'd7, -64'd2, -64'd3, 66);
    add("rem_negb",    3'd6, 1'b0, 64'd7, -64'd2, 64'd1, 66);
    add("divu",        3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    add("remu",        3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    add("divu_zero",   3'd5, 1'b0, 64'd7, 64'd0, '1, SP);
    add("remu_zero",   3'd7, 1'b0, 64'd7, 64'd0, 64'd7, SP);
    add("div_ovf",     3'd4, 1'b0, 64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, SP);
    add("rem_ovf",     3'd6, 1'b0, 64'h8000_0000_0000_0000, -64'd1, 64'd0, SP);
    add("mul_zero",    3'd0, 1'b0, 64'd0, 64'd5, 64'd0, SP);
    add("divw_ovf",    3'd4, 1'b1, 64'h0000_0001_8000_0000, -64'd1, 64'hFFFF_FFFF_8000_0000, SPW);
    add("mulw",        3'd0, 1'b1, 64'h0000_0001_0000_0003, -64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 34);
    add("mulhu_w",     3'd3, 1'b1, 64'h0000_0000_0001_0001, 64'h0000_0000_0001_0001,
        64'h0000_0000_0002_0001, 34);
    add("remw",        3'd6, 1'b1, -64'd7, 64'd2, -64'd1, 34);

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done(vecs[i].name, vecs[i].lat, -1);
    end

    // Start pulsed mid-CALC must not disturb the running multiply
    @(negedge clk);
    issue(3'd0, 1'b0, -64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("glitch_mul", 66, 10);

    // Start in the DONE cycle chains a second operation
    @(negedge clk);
    issue(3'd0, 1'b0, 64'd6, 64'd9, 64'd54);
    wait_done("b2b_first", 66, -1);
    issue(3'd4, 1'b0, -64'd7, 64'd2, -64'd3);
    wait_done("b2b_second", 66, -1);

    // Reset during CALC aborts without a done pulse
    @(negedge clk);
    issue(3'd0, 1'b0, -64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.result", result, 64'd0);
    reset = 1'b0;
    exp_q.delete();
    saw_done = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort.no_done", 64'(saw_done), 64'd0);
    $display("abort: busy=%0b result=%h", busy, result);

    issue(3'd0, 1'b0, 64'd5, 64'd6, 64'd30);
    wait_done("after_abort_mul", 66, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
